// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings and limits for the time/alarm display path.
//   state_t    - display/edit mode of clock_set_ctrl
//   field_t    - which time field is selected for editing
//   HOUR_MAX / MINSEC_MAX - wrap limits for binary hour and minute/second
//   BLANK_*    - digit-blank masks (bit0 = sec ones ... bit5 = hour tens)
package clock_pkg;

    typedef enum logic [1:0] {
        SHOW_TIME  = 2'd0,
        SHOW_ALARM = 2'd1,
        EDIT_TIME  = 2'd2,
        EDIT_ALARM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_t;

    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINSEC_MAX = 8'd59;

    localparam logic [5:0] BLANK_HOUR = 6'b110000;
    localparam logic [5:0] BLANK_MIN  = 6'b001100;
    localparam logic [5:0] BLANK_SEC  = 6'b000011;

    function automatic logic [5:0] field_mask(input field_t f);
        logic [5:0] m;
        case (f)
            FLD_HOUR: m = BLANK_HOUR;
            FLD_MIN:  m = BLANK_MIN;
            FLD_SEC:  m = BLANK_SEC;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_field_inc.sv
// clock_field_inc: combinational increment of one binary time field with wrap.
//   i_value - current field value (binary)
//   i_field - field selector; hours wrap 23->0, minutes/seconds wrap 59->0
//   o_value - incremented value
import clock_pkg::*;

module clock_field_inc (
    input  logic [7:0] i_value,
    input  field_t     i_field,
    output logic [7:0] o_value
);

    logic [7:0] w_max;

    always_comb begin
        w_max   = (i_field == FLD_HOUR) ? HOUR_MAX : MINSEC_MAX;
        // >= also folds any out-of-range value back to zero
        o_value = (i_value >= w_max) ? '0 : i_value + 8'd1;
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/edit controller for the 6-digit time/alarm display.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   tick_1hz                     - one-cycle pulse per second
//   key_mode/key_set/key_inc     - debounced one-cycle key pulses
//   alarm_en                     - alarm enable switch (level)
//   sec_reg/min_reg/hour_reg     - running time (binary)
//   time_clock_key               - 2'b01 show running time, 2'b10 show *_disp
//   sec_disp/min_disp/hour_disp  - alarm registers or edit shadow
//   blank                        - per-digit blanking for blinking the edit field
//   time_load, load_*            - one-cycle commit of edited time
//   alarm_ring                   - alarm sounding (level)
import clock_pkg::*;

module clock_set_ctrl #(
    parameter int unsigned BLINK_HALF   = 25_000_000,
    parameter int unsigned EDIT_TIMEOUT = 30,
    parameter int unsigned RING_SECS    = 60,
    parameter logic [7:0]  ALARM_H_RST  = 8'd7,
    parameter logic [7:0]  ALARM_M_RST  = 8'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       alarm_en,
    input  logic [7:0] sec_reg,
    input  logic [7:0] min_reg,
    input  logic [7:0] hour_reg,
    output logic [1:0] time_clock_key,
    output logic [7:0] sec_disp,
    output logic [7:0] min_disp,
    output logic [7:0] hour_disp,
    output logic [5:0] blank,
    output logic       time_load,
    output logic [7:0] load_sec,
    output logic [7:0] load_min,
    output logic [7:0] load_hour,
    output logic       alarm_ring
);

    localparam int unsigned TO_W = $clog2(EDIT_TIMEOUT + 1);
    localparam int unsigned RG_W = $clog2(RING_SECS + 1);
    localparam int unsigned BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    state_t          r_state;
    field_t          r_field;
    logic [7:0]      r_sh_h, r_sh_m, r_sh_s;
    logic [7:0]      r_al_h, r_al_m, r_al_s;
    logic [TO_W-1:0] r_to_cnt;
    logic [RG_W-1:0] r_ring_cnt;
    logic            r_ring;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_phase;

    state_t     w_state_nx;
    field_t     w_field_nx;
    logic [7:0] w_sh_h_nx, w_sh_m_nx, w_sh_s_nx;
    logic [7:0] w_al_h_nx, w_al_m_nx, w_al_s_nx;
    logic       w_commit_time;
    logic       w_to_clr, w_to_inc;
    logic       w_any_key, w_ringing, w_edit, w_nx_edit, w_match;
    logic [7:0] w_fld_val, w_fld_inc;

    assign w_any_key = key_mode | key_set | key_inc;
    // alarm_en low silences the output at once, not only from the next edge
    assign w_ringing = r_ring & alarm_en;
    assign w_edit    = (r_state == EDIT_TIME) || (r_state == EDIT_ALARM);
    assign w_nx_edit = (w_state_nx == EDIT_TIME) || (w_state_nx == EDIT_ALARM);
    assign w_match   = (hour_reg == r_al_h) && (min_reg == r_al_m) && (sec_reg == r_al_s);

    always_comb begin
        case (r_field)
            FLD_HOUR: w_fld_val = r_sh_h;
            FLD_MIN:  w_fld_val = r_sh_m;
            default:  w_fld_val = r_sh_s;
        endcase
    end

    clock_field_inc u_field_inc (
        .i_value (w_fld_val),
        .i_field (r_field),
        .o_value (w_fld_inc)
    );

    // Next-state / datapath decode. A pulse while ringing is swallowed here.
    always_comb begin
        w_state_nx    = r_state;
        w_field_nx    = r_field;
        w_sh_h_nx     = r_sh_h;
        w_sh_m_nx     = r_sh_m;
        w_sh_s_nx     = r_sh_s;
        w_al_h_nx     = r_al_h;
        w_al_m_nx     = r_al_m;
        w_al_s_nx     = r_al_s;
        w_commit_time = 1'b0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;

        if (w_any_key) begin
            w_to_clr = 1'b1;
            if (!w_ringing) begin
                case (r_state)
                    SHOW_TIME: begin
                        if (key_mode) begin
                            w_state_nx = SHOW_ALARM;
                        end else if (key_set) begin
                            w_state_nx = EDIT_TIME;
                            w_field_nx = FLD_HOUR;
                            w_sh_h_nx  = hour_reg;
                            w_sh_m_nx  = min_reg;
                            w_sh_s_nx  = sec_reg;
                        end
                    end
                    SHOW_ALARM: begin
                        if (key_mode) begin
                            w_state_nx = SHOW_TIME;
                        end else if (key_set) begin
                            w_state_nx = EDIT_ALARM;
                            w_field_nx = FLD_HOUR;
                            w_sh_h_nx  = r_al_h;
                            w_sh_m_nx  = r_al_m;
                            w_sh_s_nx  = r_al_s;
                        end
                    end
                    default: begin
                        if (key_mode) begin
                            w_state_nx = (r_state == EDIT_TIME) ? SHOW_TIME : SHOW_ALARM;
                        end else if (key_set) begin
                            case (r_field)
                                FLD_HOUR: w_field_nx = FLD_MIN;
                                FLD_MIN:  w_field_nx = FLD_SEC;
                                default: begin
                                    if (r_state == EDIT_TIME) begin
                                        w_state_nx    = SHOW_TIME;
                                        w_commit_time = 1'b1;
                                    end else begin
                                        w_state_nx = SHOW_ALARM;
                                        w_al_h_nx  = r_sh_h;
                                        w_al_m_nx  = r_sh_m;
                                        w_al_s_nx  = r_sh_s;
                                    end
                                end
                            endcase
                        end else begin
                            case (r_field)
                                FLD_HOUR: w_sh_h_nx = w_fld_inc;
                                FLD_MIN:  w_sh_m_nx = w_fld_inc;
                                default:  w_sh_s_nx = w_fld_inc;
                            endcase
                        end
                    end
                endcase
            end
        end else if (w_edit && tick_1hz) begin
            if (r_to_cnt == TO_W'(EDIT_TIMEOUT - 1)) begin
                w_state_nx = (r_state == EDIT_TIME) ? SHOW_TIME : SHOW_ALARM;
                w_to_clr   = 1'b1;
            end else begin
                w_to_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= SHOW_TIME;
            r_field        <= FLD_HOUR;
            r_sh_h         <= '0;
            r_sh_m         <= '0;
            r_sh_s         <= '0;
            r_al_h         <= ALARM_H_RST;
            r_al_m         <= ALARM_M_RST;
            r_al_s         <= '0;
            r_to_cnt       <= '0;
            time_clock_key <= 2'b01;
            hour_disp      <= ALARM_H_RST;
            min_disp       <= ALARM_M_RST;
            sec_disp       <= '0;
            time_load      <= 1'b0;
            load_hour      <= '0;
            load_min       <= '0;
            load_sec       <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_field   <= w_field_nx;
            r_sh_h    <= w_sh_h_nx;
            r_sh_m    <= w_sh_m_nx;
            r_sh_s    <= w_sh_s_nx;
            r_al_h    <= w_al_h_nx;
            r_al_m    <= w_al_m_nx;
            r_al_s    <= w_al_s_nx;
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            // display registers track the next state so they change with it
            time_clock_key <= (w_state_nx == SHOW_TIME) ? 2'b01 : 2'b10;
            hour_disp      <= w_nx_edit ? w_sh_h_nx : w_al_h_nx;
            min_disp       <= w_nx_edit ? w_sh_m_nx : w_al_m_nx;
            sec_disp       <= w_nx_edit ? w_sh_s_nx : w_al_s_nx;
            time_load      <= w_commit_time;
            if (w_commit_time) begin
                load_hour <= r_sh_h;
                load_min  <= r_sh_m;
                load_sec  <= r_sh_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (!alarm_en) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (w_any_key && r_ring) begin
            r_ring <= 1'b0;
        end else if (tick_1hz && (r_state != EDIT_TIME) && w_match) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= '0;
        end else if (tick_1hz && r_ring) begin
            if (r_ring_cnt == RG_W'(RING_SECS - 1)) begin
                r_ring <= 1'b0;
            end else begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
            end
        end
    end

    assign alarm_ring = w_ringing;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign blank = (w_edit && r_phase) ? field_mask(r_field) : '0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_mode = 1'b0, key_set = 1'b0, key_inc = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] sec_reg = '0, min_reg = '0, hour_reg = '0;
    logic [1:0] time_clock_key;
    logic [7:0] sec_disp, min_disp, hour_disp;
    logic [5:0] blank;
    logic       time_load;
    logic [7:0] load_sec, load_min, load_hour;
    logic       alarm_ring;

    int total = 0;
    int bad   = 0;
    int load_cnt = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .BLINK_HALF   (4),
        .EDIT_TIMEOUT (30),
        .RING_SECS    (60),
        .ALARM_H_RST  (8'd7),
        .ALARM_M_RST  (8'd0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick_1hz       (tick_1hz),
        .key_mode       (key_mode),
        .key_set        (key_set),
        .key_inc        (key_inc),
        .alarm_en       (alarm_en),
        .sec_reg        (sec_reg),
        .min_reg        (min_reg),
        .hour_reg       (hour_reg),
        .time_clock_key (time_clock_key),
        .sec_disp       (sec_disp),
        .min_disp       (min_disp),
        .hour_disp      (hour_disp),
        .blank          (blank),
        .time_load      (time_load),
        .load_sec       (load_sec),
        .load_min       (load_min),
        .load_hour      (load_hour),
        .alarm_ring     (alarm_ring)
    );

    always @(negedge clk) if (time_load === 1'b1) load_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic m, input logic s, input logic i);
        @(negedge clk);
        key_mode = m; key_set = s; key_inc = i;
        @(negedge clk);
        key_mode = 1'b0; key_set = 1'b0; key_inc = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] prev, v;
        logic       found;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_tck", time_clock_key, 2'b01);
        chk("rst_hour_disp", hour_disp, 7);
        chk("rst_min_disp", min_disp, 0);
        chk("rst_sec_disp", sec_disp, 0);
        chk("rst_blank", blank, 0);
        chk("rst_ring", alarm_ring, 0);
        chk("rst_load", time_load, 0);
        reset_n = 1'b1;

        // ---- edit time 12:34:56 -> 00:34:00 and commit
        hour_reg = 8'd12; min_reg = 8'd34; sec_reg = 8'd56;
        key(0, 1, 0);
        chk("et_tck", time_clock_key, 2'b10);
        chk("et_shadow_h", hour_disp, 12);
        chk("et_shadow_s", sec_disp, 56);
        repeat (12) key(0, 0, 1);
        chk("et_hour_wrap", hour_disp, 0);
        key(0, 1, 0);
        key(0, 1, 0);
        repeat (4) key(0, 0, 1);
        chk("et_sec_wrap", sec_disp, 0);
        chk("et_min_keep", min_disp, 34);
        key(0, 1, 0);
        chk("commit_pulse", time_load, 1);
        chk("commit_load_h", load_hour, 0);
        chk("commit_load_m", load_min, 34);
        chk("commit_load_s", load_sec, 0);
        chk("commit_tck", time_clock_key, 2'b01);
        chk("commit_disp_alarm", hour_disp, 7);
        @(negedge clk);
        chk("commit_pulse_end", time_load, 0);
        chk("load_hold_m", load_min, 34);
        chk("load_cnt_1", load_cnt, 1);

        // ---- edit alarm then abort at MIN
        key(1, 0, 0);
        chk("sa_tck", time_clock_key, 2'b10);
        chk("sa_disp_h", hour_disp, 7);
        key(0, 1, 0);
        key(0, 0, 1);
        chk("ea_inc_h", hour_disp, 8);
        key(0, 1, 0);
        key(0, 0, 1);
        chk("ea_inc_m", min_disp, 1);
        key(1, 0, 0);
        chk("ea_abort_tck", time_clock_key, 2'b10);
        chk("ea_abort_h", hour_disp, 7);
        chk("ea_abort_m", min_disp, 0);
        chk("ea_abort_noload", load_cnt, 1);
        key(1, 0, 0);
        chk("back_show_time", time_clock_key, 2'b01);

        // ---- key priority
        key(1, 1, 0);
        chk("prio_mode_over_set", time_clock_key, 2'b10);
        key(1, 0, 0);
        key(0, 1, 0);
        key(0, 1, 1);
        chk("prio_set_over_inc", hour_disp, 12);
        key(0, 0, 1);
        chk("prio_field_min", min_disp, 35);
        key(1, 0, 1);
        chk("prio_mode_over_inc", time_clock_key, 2'b01);
        chk("prio_noload", load_cnt, 1);

        // ---- blink and timeout
        key(0, 1, 0);
        prev = blank; found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (blank !== prev) found = 1'b1;
            else prev = blank;
        end
        chk("blink_edge_found", found, 1);
        v = blank;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("blink_hold", blank, v);
        end
        @(negedge clk);
        chk("blink_toggle", blank, v ^ 6'b110000);
        key(0, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (blank != 0) found = 1'b1;
        end
        chk("blink_min_mask", blank, 6'b001100);
        repeat (29) tick();
        chk("to_not_yet", time_clock_key, 2'b10);
        tick();
        chk("to_abort", time_clock_key, 2'b01);
        chk("to_noload", load_cnt, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("show_blank_off", blank, 0);
        end

        // ---- alarm ring
        alarm_en = 1'b1;
        hour_reg = 8'd6; min_reg = 8'd59; sec_reg = 8'd59;
        tick();
        chk("ring_no_match", alarm_ring, 0);
        hour_reg = 8'd7; min_reg = 8'd0; sec_reg = 8'd0;
        tick();
        chk("ring_set", alarm_ring, 1);
        sec_reg = 8'd1;
        key(1, 0, 0);
        chk("ring_key_clear", alarm_ring, 0);
        chk("ring_key_consumed", time_clock_key, 2'b01);
        sec_reg = 8'd0;
        tick();
        chk("ring_set2", alarm_ring, 1);
        sec_reg = 8'd1;
        repeat (59) tick();
        chk("ring_59", alarm_ring, 1);
        tick();
        chk("ring_60_off", alarm_ring, 0);
        sec_reg = 8'd0;
        tick();
        chk("ring_set3", alarm_ring, 1);
        @(negedge clk);
        alarm_en = 1'b0;
        #1;
        chk("ring_en_off", alarm_ring, 0);
        @(negedge clk);
        alarm_en = 1'b1;
        #1;
        chk("ring_stays_off", alarm_ring, 0);
        key(0, 1, 0);
        tick();
        chk("ring_blocked_edit", alarm_ring, 0);
        key(1, 0, 0);

        // ---- alarm commit, then reset mid-edit
        sec_reg = 8'd5;
        key(1, 0, 0);
        key(0, 1, 0);
        key(0, 0, 1);
        key(0, 1, 0);
        key(0, 1, 0);
        key(0, 1, 0);
        chk("al_commit_h", hour_disp, 8);
        chk("al_commit_tck", time_clock_key, 2'b10);
        chk("al_commit_noload", load_cnt, 1);
        key(0, 1, 0);
        key(0, 0, 1);
        chk("pre_rst_h", hour_disp, 9);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_h", hour_disp, 7);
        chk("mid_rst_tck", time_clock_key, 2'b01);
        chk("mid_rst_blank", blank, 0);
        chk("mid_rst_load", time_load, 0);
        @(negedge clk);
        reset_n = 1'b1;
        key(1, 0, 0);
        chk("post_rst_alarm_h", hour_disp, 7);
        chk("final_load_cnt", load_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
